// File: rtl/wavelet_core_level_seq.sv
// Level sequencer for the wavelet core: loads filter coefficients, then walks
// decomposition levels 0..core_dec_level generating buffer read/write addresses.
//
// state      | meaning
// IDLE       | waiting for start
// INIT_SETUP | latch coefficient count, clear datapath
// INIT_RD    | stream coefficients from ibuff
// LVL_SETUP  | latch level lengths, clear datapath
// LVL_RD     | stream level samples, accept outputs
// LVL_DRAIN  | all samples issued, waiting for remaining outputs
// LVL_NEXT   | advance detail base, pick next level or finish
// FIN        | one-cycle done pulse
module wavelet_core_level_seq #(
   parameter int IBUFF_CELL_COUNT = 2048,
   parameter int OBUFF_CELL_COUNT = 2048,
   parameter int IBUFF_ADDR_WIDTH = $clog2(IBUFF_CELL_COUNT),
   parameter int OBUFF_ADDR_WIDTH = $clog2(OBUFF_CELL_COUNT),
   parameter int COEF_BASE        = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [1:0]                  core_dec_level,
   input  logic [IBUFF_ADDR_WIDTH-1:0] cur_inputs_len,
   input  logic [OBUFF_ADDR_WIDTH-1:0] cur_outputs_len,
   input  logic [OBUFF_ADDR_WIDTH-1:0] obuff_w_approx_addr,
   input  logic                        src_ready,
   input  logic                        mac_valid,
   output logic                        core_init,
   output logic [1:0]                  cur_dec_level,
   output logic                        dp_clear,
   output logic                        ibuff_r_en,
   output logic [IBUFF_ADDR_WIDTH-1:0] ibuff_r_addr,
   output logic                        ibuff_w_en,
   output logic [IBUFF_ADDR_WIDTH-1:0] ibuff_w_addr,
   output logic                        obuff_det_we,
   output logic [OBUFF_ADDR_WIDTH-1:0] obuff_det_addr,
   output logic                        obuff_apx_we,
   output logic [OBUFF_ADDR_WIDTH-1:0] obuff_apx_addr,
   output logic                        busy,
   output logic                        done,
   output logic                        err
);

   typedef enum logic [2:0] {
      IDLE, INIT_SETUP, INIT_RD, LVL_SETUP, LVL_RD, LVL_DRAIN, LVL_NEXT, FIN
   } state_t;

   localparam logic [IBUFF_ADDR_WIDTH-1:0] COEF_BASE_A = IBUFF_ADDR_WIDTH'(COEF_BASE);

   state_t                      state_q, state_d;
   logic [IBUFF_ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
   logic [IBUFF_ADDR_WIDTH-1:0] in_len_q, in_len_d;
   logic [OBUFF_ADDR_WIDTH-1:0] out_cnt_q, out_cnt_d;
   logic [OBUFF_ADDR_WIDTH-1:0] out_len_q, out_len_d;
   logic [OBUFF_ADDR_WIDTH-1:0] det_base_q, det_base_d;
   logic [1:0]                  lvl_q, lvl_d;
   logic                        err_q, err_d;

   logic rd_last, rd_go, rd_all, out_ok, out_all, lvl_last;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         rd_cnt_q   <= '0;
         in_len_q   <= '0;
         out_cnt_q  <= '0;
         out_len_q  <= '0;
         det_base_q <= '0;
         lvl_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_cnt_q   <= rd_cnt_d;
         in_len_q   <= in_len_d;
         out_cnt_q  <= out_cnt_d;
         out_len_q  <= out_len_d;
         det_base_q <= det_base_d;
         lvl_q      <= lvl_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      rd_cnt_d   = rd_cnt_q;
      in_len_d   = in_len_q;
      out_cnt_d  = out_cnt_q;
      out_len_d  = out_len_q;
      det_base_d = det_base_q;
      lvl_d      = lvl_q;
      err_d      = err_q;

      core_init      = 1'b0;
      dp_clear       = 1'b0;
      ibuff_r_en     = 1'b0;
      ibuff_r_addr   = '0;
      ibuff_w_en     = 1'b0;
      ibuff_w_addr   = '0;
      obuff_det_we   = 1'b0;
      obuff_det_addr = '0;
      obuff_apx_we   = 1'b0;
      obuff_apx_addr = '0;
      busy           = (state_q != IDLE);
      done           = 1'b0;

      rd_last  = (in_len_q != '0) && (rd_cnt_q == in_len_q - 1'b1);
      rd_go    = src_ready && (rd_cnt_q < in_len_q);
      rd_all   = (rd_cnt_q == in_len_q) || (rd_go && rd_last && state_q == LVL_RD);
      out_ok   = mac_valid && (out_cnt_q != out_len_q);
      out_all  = (out_cnt_q == out_len_q) || (out_ok && out_cnt_q == out_len_q - 1'b1);
      lvl_last = (lvl_q == core_dec_level);

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = INIT_SETUP;
               err_d   = 1'b0;
               lvl_d   = '0;
            end
         end
         INIT_SETUP: begin
            core_init = 1'b1;
            dp_clear  = 1'b1;
            in_len_d  = cur_inputs_len;
            rd_cnt_d  = '0;
            state_d   = INIT_RD;
         end
         INIT_RD: begin
            core_init    = 1'b1;
            ibuff_r_addr = COEF_BASE_A + rd_cnt_q;
            if (rd_go) begin
               ibuff_r_en = 1'b1;
               rd_cnt_d   = rd_cnt_q + 1'b1;
            end
            if ((in_len_q == '0) || (rd_go && rd_last)) begin
               state_d    = LVL_SETUP;
               lvl_d      = '0;
               det_base_d = '0;
            end
         end
         LVL_SETUP: begin
            dp_clear  = 1'b1;
            in_len_d  = cur_inputs_len;
            out_len_d = cur_outputs_len;
            rd_cnt_d  = '0;
            out_cnt_d = '0;
            state_d   = LVL_RD;
         end
         LVL_RD, LVL_DRAIN: begin
            if (state_q == LVL_RD && rd_go) begin
               ibuff_r_en   = 1'b1;
               ibuff_r_addr = rd_cnt_q;
               rd_cnt_d     = rd_cnt_q + 1'b1;
            end
            // out_cnt never passes out_len, so an extra pulse only flags err
            if (mac_valid) begin
               if (out_ok) begin
                  obuff_det_we   = 1'b1;
                  obuff_det_addr = det_base_q + out_cnt_q;
                  if (lvl_last) begin
                     obuff_apx_we   = 1'b1;
                     obuff_apx_addr = obuff_w_approx_addr + out_cnt_q;
                  end else begin
                     ibuff_w_en   = 1'b1;
                     ibuff_w_addr = IBUFF_ADDR_WIDTH'(out_cnt_q);
                  end
                  out_cnt_d = out_cnt_q + 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
            if (state_q == LVL_RD) begin
               if (rd_all && out_all) state_d = LVL_NEXT;
               else if (rd_all)       state_d = LVL_DRAIN;
            end else if (out_all) begin
               state_d = LVL_NEXT;
            end
         end
         LVL_NEXT: begin
            det_base_d = det_base_q + out_len_q;
            if (lvl_last) begin
               state_d = FIN;
            end else begin
               lvl_d   = lvl_q + 1'b1;
               state_d = LVL_SETUP;
            end
         end
         FIN: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign cur_dec_level = lvl_q;
   assign err           = err_q;

endmodule

// File: tb/tb_wavelet_core_level_seq.sv
// Directed bench for the wavelet level sequencer; models the io-length block
// and checks every strobe/address cycle by cycle against hand-derived values.
module tb_wavelet_core_level_seq;

   localparam int AW   = 11;
   localparam int COEF = 16;

   logic          clk = 1'b0;
   logic          rst, start, src_ready, mac_valid;
   logic [1:0]    core_dec_level;
   logic [AW-1:0] cur_inputs_len, cur_outputs_len, obuff_w_approx_addr;
   logic          core_init, dp_clear, ibuff_r_en, ibuff_w_en;
   logic          obuff_det_we, obuff_apx_we, busy, done, err;
   logic [1:0]    cur_dec_level;
   logic [AW-1:0] ibuff_r_addr, ibuff_w_addr, obuff_det_addr, obuff_apx_addr;

   logic [AW-1:0] init_len, l0_in, l0_out, l1_in, l1_out;
   int            n_checks = 0;
   int            n_errors = 0;
   bit            exp_err  = 1'b0;

   always #5 clk = ~clk;

   // io-length block stand-in
   assign cur_inputs_len  = core_init ? init_len : (cur_dec_level == 2'd0 ? l0_in : l1_in);
   assign cur_outputs_len = (cur_dec_level == 2'd0) ? l0_out : l1_out;

   wavelet_core_level_seq #(.COEF_BASE(COEF)) dut (
      .clk(clk), .rst(rst), .start(start), .core_dec_level(core_dec_level),
      .cur_inputs_len(cur_inputs_len), .cur_outputs_len(cur_outputs_len),
      .obuff_w_approx_addr(obuff_w_approx_addr), .src_ready(src_ready),
      .mac_valid(mac_valid), .core_init(core_init), .cur_dec_level(cur_dec_level),
      .dp_clear(dp_clear), .ibuff_r_en(ibuff_r_en), .ibuff_r_addr(ibuff_r_addr),
      .ibuff_w_en(ibuff_w_en), .ibuff_w_addr(ibuff_w_addr),
      .obuff_det_we(obuff_det_we), .obuff_det_addr(obuff_det_addr),
      .obuff_apx_we(obuff_apx_we), .obuff_apx_addr(obuff_apx_addr),
      .busy(busy), .done(done), .err(err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Entered at a negedge with the DUT in IDLE; leaves it at LVL_SETUP.
   task automatic run_init(input int n);
      start = 1'b1; mac_valid = 1'b1; src_ready = 1'b1;
      #1;
      chk("idle_busy", busy, 0);
      chk("idle_err", err, exp_err);
      exp_err = 1'b0;
      tick();
      #1;
      chk("is_core_init", core_init, 1);
      chk("is_dp_clear", dp_clear, 1);
      chk("is_busy", busy, 1);
      chk("is_rd_en", ibuff_r_en, 0);
      chk("is_err_clr", err, 0);
      tick();
      start = 1'b0;
      for (int i = 0; i < n; i++) begin
         #1;
         chk("ir_core_init", core_init, 1);
         chk("ir_rd_en", ibuff_r_en, 1);
         chk("ir_rd_addr", ibuff_r_addr, COEF + i);
         chk("ir_det_we", obuff_det_we, 0);
         chk("ir_apx_we", obuff_apx_we, 0);
         chk("ir_w_en", ibuff_w_en, 0);
         tick();
      end
      if (n == 0) begin
         #1;
         chk("ir0_core_init", core_init, 1);
         chk("ir0_rd_en", ibuff_r_en, 0);
         tick();
      end
      mac_valid = 1'b0;
   endtask

   // Entered at LVL_SETUP; mac pulses follow reads at 1 per `ratio` samples.
   task automatic run_level(input int lvl, input int n_in, input int n_out, input int det_b,
                            input bit last, input int apx_base, input bit stall,
                            input int ratio, input int extra, input int abort_after);
      int  rd  = 0;
      int  ms  = 0;
      int  cyc = 0;
      bit  r_exp, wr_ok;
      src_ready = 1'b1; mac_valid = 1'b0;
      #1;
      chk("ls_dp_clear", dp_clear, 1);
      chk("ls_core_init", core_init, 0);
      chk("ls_level", cur_dec_level, lvl);
      chk("ls_rd_en", ibuff_r_en, 0);
      tick();
      forever begin
         src_ready = stall ? (cyc % 3 == 0) : 1'b1;
         mac_valid = (ms < n_out + extra) && ((rd >= ratio * ms + ratio) || (rd == n_in));
         #1;
         r_exp = src_ready && (rd < n_in);
         wr_ok = mac_valid && (ms < n_out);
         chk("lv_rd_en", ibuff_r_en, r_exp);
         if (r_exp) chk("lv_rd_addr", ibuff_r_addr, rd);
         chk("lv_det_we", obuff_det_we, wr_ok);
         chk("lv_apx_we", obuff_apx_we, wr_ok && last);
         chk("lv_w_en", ibuff_w_en, wr_ok && !last);
         if (wr_ok) begin
            chk("lv_det_addr", obuff_det_addr, (det_b + ms) % 2048);
            if (last) chk("lv_apx_addr", obuff_apx_addr, (apx_base + ms) % 2048);
            else      chk("lv_w_addr", ibuff_w_addr, ms);
         end
         chk("lv_err", err, exp_err);
         chk("lv_level", cur_dec_level, lvl);
         chk("lv_busy", busy, 1);
         if (r_exp) rd++;
         if (mac_valid) begin
            if (ms >= n_out) exp_err = 1'b1;
            ms++;
         end
         cyc++;
         tick();
         if (abort_after != 0 && cyc == abort_after) return;
         if (rd == n_in && ms == n_out + extra) break;
         if (cyc > 5000) begin
            n_checks++;
            n_errors++;
            $error("FAIL level_budget observed=%0d reads expected=%0d", rd, n_in);
            break;
         end
      end
      mac_valid = 1'b0;
      #1;
      chk("ln_busy", busy, 1);
      chk("ln_rd_en", ibuff_r_en, 0);
      chk("ln_det_we", obuff_det_we, 0);
      chk("ln_done", done, 0);
      chk("ln_dp_clear", dp_clear, 0);
      tick();
      if (last) begin
         #1;
         chk("fin_done", done, 1);
         chk("fin_busy", busy, 1);
         tick();
         #1;
         chk("end_done", done, 0);
         chk("end_busy", busy, 0);
         chk("end_err", err, exp_err);
      end
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; src_ready = 1'b0; mac_valid = 1'b0;
      core_dec_level = 2'd0; obuff_w_approx_addr = 11'd500;
      init_len = 11'd18; l0_in = 11'd264; l0_out = 11'd132; l1_in = 11'd140; l1_out = 11'd70;
      @(negedge clk);
      tick(); tick();
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_core_init", core_init, 0);
      chk("rst_rd_en", ibuff_r_en, 0);
      chk("rst_level", cur_dec_level, 0);
      rst = 1'b1;
      tick();

      // single level, final approx at 500
      run_init(18);
      run_level(0, 264, 132, 0, 1'b1, 500, 1'b0, 2, 0, 0);

      // two levels with stalled reads on level 1
      core_dec_level = 2'd1; obuff_w_approx_addr = 11'd202;
      run_init(18);
      run_level(0, 264, 132, 0, 1'b0, 0, 1'b0, 2, 0, 0);
      run_level(1, 140, 70, 132, 1'b1, 202, 1'b1, 2, 0, 0);

      // overrun: one pulse beyond out_len
      core_dec_level = 2'd0; obuff_w_approx_addr = 11'd1536;
      run_init(18);
      run_level(0, 264, 132, 0, 1'b1, 1536, 1'b0, 1, 1, 0);
      tick();
      #1;
      chk("ovr_err_held", err, 1);

      // zero-length phases, also clears sticky err
      init_len = 11'd0; l0_in = 11'd0; l0_out = 11'd0;
      run_init(0);
      run_level(0, 0, 0, 0, 1'b1, 1536, 1'b0, 2, 0, 0);

      // reset during level 1 reads
      init_len = 11'd18; l0_in = 11'd264; l0_out = 11'd132;
      core_dec_level = 2'd1; obuff_w_approx_addr = 11'd202;
      run_init(18);
      run_level(0, 264, 132, 0, 1'b0, 0, 1'b0, 2, 0, 0);
      run_level(1, 140, 70, 132, 1'b1, 202, 1'b0, 2, 0, 20);
      rst = 1'b0; src_ready = 1'b1; mac_valid = 1'b1;
      tick();
      #1;
      chk("mr_busy", busy, 0);
      chk("mr_core_init", core_init, 0);
      chk("mr_level", cur_dec_level, 0);
      chk("mr_dp_clear", dp_clear, 0);
      chk("mr_rd_en", ibuff_r_en, 0);
      chk("mr_rd_addr", ibuff_r_addr, 0);
      chk("mr_w_en", ibuff_w_en, 0);
      chk("mr_det_we", obuff_det_we, 0);
      chk("mr_det_addr", obuff_det_addr, 0);
      chk("mr_apx_we", obuff_apx_we, 0);
      chk("mr_done", done, 0);
      chk("mr_err", err, 0);
      rst = 1'b1; mac_valid = 1'b0;
      tick();
      core_dec_level = 2'd0; obuff_w_approx_addr = 11'd500;
      run_init(18);
      run_level(0, 264, 132, 0, 1'b1, 500, 1'b0, 2, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
